// File: rtl/ldm_writeback.sv
// ldm_writeback: load-multiple sequencer that overlaps data-memory reads with register-file writes.
// Define LDM_WRITEBACK_WBACK_EN to enable base-register writeback through the second write port.
module ldm_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] reglist,
    input  logic [31:0] base,
    input  logic [3:0]  rn,
    input  logic        up,
    input  logic        wback,
    output logic        busy,
    output logic        done,
    output logic        dmem_re,
    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_rdata,
    output logic        we3,
    output logic [3:0]  a3,
    output logic [31:0] wd3,
    output logic [3:0]  a4,
    output logic [31:0] wd4,
    output logic        long,
    output logic        pc_we,
    output logic [31:0] pc_wd
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [15:0] rem, rem_nx;
    logic [31:0] addr, four_n;
    logic [4:0]  cnt;
    logic [3:0]  cur, wr_reg;
    logic        wr_v;
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) cnt = cnt + {4'b0, reglist[i]};
        cur = '0;
        for (int i = 15; i >= 0; i--) if (rem[i]) cur = 4'(i);
        four_n = {25'b0, cnt, 2'b0};
        rem_nx = rem & (rem - 16'd1);
        state_nx = state == IDLE ? (start ? (cnt == 5'd0 ? DRAIN : RUN) : IDLE) :
                   state == RUN  ? (rem_nx == 16'd0 ? DRAIN : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rem    <= '0;
            addr   <= '0;
            wr_v   <= 1'b0;
            wr_reg <= '0;
        end else begin
            state  <= state_nx;
            wr_v   <= state == RUN;
            wr_reg <= cur;
            if (state == IDLE && start) begin
                rem  <= reglist;
                addr <= up ? base : base - four_n;
            end else if (state == RUN) begin
                rem  <= rem_nx;
                addr <= addr + 32'd4;
            end
        end
    end
    assign busy      = state != IDLE;
    assign done      = state == DRAIN;
    assign dmem_re   = state == RUN;
    assign dmem_addr = dmem_re ? addr : '0;
    // The write stage trails the read by one cycle, so it is driven straight from the returning data.
    assign we3   = wr_v && wr_reg != 4'd15;
    assign a3    = we3 ? wr_reg : '0;
    assign wd3   = we3 ? dmem_rdata : '0;
    assign pc_we = wr_v && wr_reg == 4'd15;
    assign pc_wd = pc_we ? {dmem_rdata[31:2], 2'b00} : '0;
`ifdef LDM_WRITEBACK_WBACK_EN
    logic [3:0]  wb_rn;
    logic [31:0] wb_val;
    logic        wb_long;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_rn   <= '0;
            wb_val  <= '0;
            wb_long <= 1'b0;
        end else if (state == IDLE && start) begin
            wb_rn   <= rn;
            wb_val  <= up ? base + four_n : base - four_n;
            wb_long <= wback && cnt != 5'd0 && !reglist[rn];
        end
    end
    assign long = done && wb_long;
    assign a4   = long ? wb_rn : '0;
    assign wd4  = long ? wb_val : '0;
`else
    assign {long, a4, wd4} = {37{1'b0}} & {wback, rn, 32'h0};
`endif
endmodule

// File: tb/tb_ldm_writeback.sv
// tb_ldm_writeback: scoreboard bench for ldm_writeback; expected reads, writes, PC loads,
// base writebacks and done pulses are queued with their cycle offsets and checked by a monitor.
module tb_ldm_writeback;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, up = 1'b0, wback = 1'b0;
    logic [15:0] reglist = '0;
    logic [31:0] base = '0, dmem_rdata = '0;
    logic [3:0]  rn = '0;
    logic        busy, done, dmem_re, we3, long, pc_we;
    logic [31:0] dmem_addr, wd3, wd4, pc_wd;
    logic [3:0]  a3, a4;

    ldm_writeback dut (
        .clk(clk), .reset(reset), .start(start), .reglist(reglist), .base(base), .rn(rn),
        .up(up), .wback(wback), .busy(busy), .done(done), .dmem_re(dmem_re),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .we3(we3), .a3(a3), .wd3(wd3),
        .a4(a4), .wd4(wd4), .long(long), .pc_we(pc_we), .pc_wd(pc_wd)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; logic [3:0] r; logic [31:0] v;} ev_t;
    ev_t rd_q[$], wr_q[$], pc_q[$], lg_q[$];
    int  dn_q[$];
    logic [31:0] mem [logic [31:0]];
    int cyc = 0, t0 = 0, n_chk = 0, n_fail = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hDEAD0000);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic surprise(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL unexpected %s at cycle %0d", nm, cyc - t0);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dmem_re) dmem_rdata <= rd(dmem_addr);
    end

    always @(negedge clk) if (reset) begin
        ev_t e;
        int  d;
        if (dmem_re) begin
            if (rd_q.size() == 0) surprise("read");
            else begin e = rd_q.pop_front(); chk("rd_cycle", cyc - t0, e.cyc); chk("rd_addr", dmem_addr, e.v); end
        end
        if (we3) begin
            if (wr_q.size() == 0) surprise("we3");
            else begin
                e = wr_q.pop_front();
                chk("wr_cycle", cyc - t0, e.cyc); chk("a3", {28'b0, a3}, {28'b0, e.r}); chk("wd3", wd3, e.v);
            end
        end
        if (pc_we) begin
            if (pc_q.size() == 0) surprise("pc_we");
            else begin e = pc_q.pop_front(); chk("pc_cycle", cyc - t0, e.cyc); chk("pc_wd", pc_wd, e.v); end
        end
        if (long) begin
            if (lg_q.size() == 0) surprise("long");
            else begin
                e = lg_q.pop_front();
                chk("long_cycle", cyc - t0, e.cyc); chk("a4", {28'b0, a4}, {28'b0, e.r}); chk("wd4", wd4, e.v);
            end
        end
        if (done) begin
            if (dn_q.size() == 0) surprise("done");
            else begin d = dn_q.pop_front(); chk("done_cycle", cyc - t0, d); end
        end
    end

    task automatic check_idle(input string nm);
        chk({nm, "_rd_q"}, rd_q.size(), 0);
        chk({nm, "_wr_q"}, wr_q.size(), 0);
        chk({nm, "_pc_q"}, pc_q.size(), 0);
        chk({nm, "_lg_q"}, lg_q.size(), 0);
        chk({nm, "_dn_q"}, dn_q.size(), 0);
        chk({nm, "_busy"}, {31'b0, busy}, 0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ctl"}, {24'b0, busy, done, dmem_re, we3, long, pc_we, 2'b0}, 0);
        chk({nm, "_addr"}, dmem_addr, 0);
        chk({nm, "_regs"}, {24'b0, a3, a4}, 0);
        chk({nm, "_wd3"}, wd3, 0);
        chk({nm, "_wd4"}, wd4, 0);
        chk({nm, "_pc_wd"}, pc_wd, 0);
    endtask

    // Queue the expected traffic, drive the request, optionally hold start through busy.
    task automatic run(input string nm, input logic [15:0] rl, input logic [31:0] b,
                       input logic [3:0] r, input logic u, input logic w, input logic hold);
        int n;
        logic [31:0] a;
        int j;
        n = $countones(rl);
        a = u ? b : b - 32'(4 * n);
        j = 0;
        for (int i = 0; i < 16; i++) if (rl[i]) begin
            j++;
            rd_q.push_back('{j, 4'(i), a});
            if (i == 15) pc_q.push_back('{j + 1, 4'd15, rd(a) & 32'hFFFFFFFC});
            else wr_q.push_back('{j + 1, 4'(i), rd(a)});
            a = a + 32'd4;
        end
        dn_q.push_back(n == 0 ? 1 : n + 1);
`ifdef LDM_WRITEBACK_WBACK_EN
        if (w && n > 0 && !rl[r])
            lg_q.push_back('{n + 1, r, u ? b + 32'(4 * n) : b - 32'(4 * n)});
`endif
        @(negedge clk);
        t0 = cyc;
        reglist = rl; base = b; rn = r; up = u; wback = w; start = 1'b1;
        if (hold) repeat (n + 1) begin
            @(negedge clk);
            reglist = 16'hA5A5; base = 32'h12345678; up = ~u;
        end else @(negedge clk);
        start = 1'b0;
        reglist = '0;
        repeat (n + 4) @(negedge clk);
        @(posedge clk); #2;
        check_idle(nm);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        reset = 1'b1;
        @(negedge clk); #1;
        check_zero("after_reset");
        mem[32'h304] = 32'h00001233;
        mem[32'h3FC] = 32'hCAFEBABF;
        run("ia_r0r2r5", 16'h0025, 32'h100, 4'd0, 1'b1, 1'b0, 1'b0);
        run("db_r1r3_wb", 16'h000A, 32'h200, 4'd4, 1'b0, 1'b1, 1'b1);
        run("r4_r15", 16'h8010, 32'h300, 4'd4, 1'b1, 1'b1, 1'b0);
        run("empty", 16'h0000, 32'h500, 4'd1, 1'b1, 1'b1, 1'b1);
        run("db_r1r15_wb", 16'h8002, 32'h400, 4'd2, 1'b0, 1'b1, 1'b0);
        run("wrap", 16'h0003, 32'hFFFFFFFC, 4'd0, 1'b1, 1'b0, 1'b0);
        run("all", 16'hFFFF, 32'h1000, 4'd3, 1'b1, 1'b1, 1'b1);
        // Abort: only the first read happens before reset lands in cycle 2.
        rd_q.push_back('{1, 4'd0, 32'hFFFFFFFC});
        @(negedge clk);
        t0 = cyc;
        reglist = 16'h0003; base = 32'hFFFFFFFC; up = 1'b1; wback = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_zero("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #2;
        check_idle("abort");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
